// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: iterative RV32M multiply/divide unit.
//   Multiplies by radix-2 shift-add and divides by radix-2 restoring
//   division, one bit per cycle. Both run on unsigned magnitudes, and the
//   sign is fixed up on the way into DONE.
//   Optional feature macro: MULDIV_DIVIDER_EN. When it is defined, the
//   divider datapath is built and all eight funct3 ops are supported. When
//   it is not defined, DIV/DIVU/REM/REMU finish in one cycle with a result
//   of 0.
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous, active-low reset
//   start_i     request pulse; only sampled in IDLE
//   funct3_i    RV32M op select (000 MUL .. 111 REMU)
//   rs1_data_i  operand A (multiplicand / dividend)
//   rs2_data_i  operand B (multiplier / divisor)
//   busy_o      high while in CALC or DONE
//   done_o      one-cycle pulse when result_o becomes valid
//   result_o    result; held until the next accepted start
module mul_div_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [2:0]     op;
  logic [W-1:0]   opb;       // multiplicand (MUL) or divisor (DIV) magnitude
  logic [2*W-1:0] prod;      // {acc, multiplier} or {remainder, dividend/quotient}
  logic [4:0]     cnt;
  logic           neg_p;     // negate product / quotient
`ifdef MULDIV_DIVIDER_EN
  logic           neg_r;     // negate remainder (sign of dividend)
`endif

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic s);
    return neg_w(v, s & v[W-1]);
  endfunction

  // Operand signedness decode and the magnitudes taken on capture
  logic         a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3_i)
      3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                 a_signed = 1'b1;
      default:                ;
    endcase
    a_neg = a_signed & rs1_data_i[W-1];
    b_neg = b_signed & rs2_data_i[W-1];
    a_mag = mag(rs1_data_i, a_signed);
    b_mag = mag(rs2_data_i, b_signed);
  end

  // One iteration step, plus the sign-corrected result taken from it
  logic [W:0]     mul_sum;
  logic [2*W-1:0] step;
  logic [2*W-1:0] p_fix;
  logic [W-1:0]   final_res;
`ifdef MULDIV_DIVIDER_EN
  logic [W:0]     trial;
  logic [W+1:0]   diff;
`endif

  always_comb begin
    mul_sum = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, opb} : {(W+1){1'b0}});
    step    = {mul_sum, prod[W-1:1]};
`ifdef MULDIV_DIVIDER_EN
    // Shift the next dividend bit into the partial remainder, then trial-subtract
    trial = prod[2*W-1:W-1];
    diff  = {1'b0, trial} - {2'b00, opb};
    if (op[2])
      step = diff[W+1] ? {trial[W-1:0], prod[W-2:0], 1'b0}
                       : {diff[W-1:0],  prod[W-2:0], 1'b1};
`endif
    p_fix = neg_2w(step, neg_p);
    case (op)
      3'b000:                 final_res = p_fix[W-1:0];
      3'b001, 3'b010, 3'b011: final_res = p_fix[2*W-1:W];
`ifdef MULDIV_DIVIDER_EN
      3'b100, 3'b101:         final_res = neg_w(step[W-1:0], neg_p);
      3'b110, 3'b111:         final_res = neg_w(step[2*W-1:W], neg_r);
`endif
      default:                final_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      op       <= '0;
      opb      <= '0;
      prod     <= '0;
      cnt      <= '0;
      neg_p    <= 1'b0;
`ifdef MULDIV_DIVIDER_EN
      neg_r    <= 1'b0;
`endif
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            op     <= funct3_i;
            cnt    <= 5'd31;
            neg_p  <= (funct3_i == 3'b010) ? a_neg : (a_neg ^ b_neg);
            busy_o <= 1'b1;
            if (funct3_i[2]) begin
              opb  <= b_mag;
              prod <= {{W{1'b0}}, a_mag};
            end else begin
              opb  <= a_mag;
              prod <= {{W{1'b0}}, b_mag};
            end
            state <= CALC;
`ifdef MULDIV_DIVIDER_EN
            neg_r <= a_neg;
            // Divide by zero and signed overflow skip the iteration
            if (funct3_i[2] && rs2_data_i == '0) begin
              state    <= DONE;
              done_o   <= 1'b1;
              result_o <= funct3_i[1] ? rs1_data_i : '1;
            end else if (funct3_i[2] && !funct3_i[0] &&
                         rs1_data_i == MIN_NEG && rs2_data_i == '1) begin
              state    <= DONE;
              done_o   <= 1'b1;
              result_o <= funct3_i[1] ? '0 : MIN_NEG;
            end
`else
            if (funct3_i[2]) begin
              state    <= DONE;
              done_o   <= 1'b1;
              result_o <= '0;
            end
`endif
          end
        end
        CALC: begin
          prod <= step;
          if (cnt == 5'd0) begin
            state    <= DONE;
            done_o   <= 1'b1;
            result_o <= final_res;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
module tb_mul_div_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  int errors = 0;
  int checks = 0;

`ifdef MULDIV_DIVIDER_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  mul_div_sequencer #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .funct3_i(funct3_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op; lat counts cycles from the start cycle to the done cycle
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic busy_first);
    @(negedge clk);
    start_i = 1'b1; funct3_i = f3; rs1_data_i = a; rs2_data_i = b;
    @(negedge clk);
    start_i = 1'b0;
    rs1_data_i = 32'hDEAD_BEEF; rs2_data_i = 32'h1234_5678; funct3_i = ~f3;
    lat = 1;
    busy_first = busy_o;
    while (!done_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = result_o;
  endtask

  vec_t vecs[$];
  int          lat, done_cnt;
  logic [31:0] res;
  logic        bf;

  initial begin
    vecs.push_back('{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33});
    vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{3'b000, 32'd12345,     32'd1000,      32'h00BC_5EA8, 33});
    vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
    vecs.push_back('{3'b100, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 33});
    vecs.push_back('{3'b110, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 33});
    vecs.push_back('{3'b101, 32'd100,       32'd7,         32'd14,        33});
    vecs.push_back('{3'b111, 32'd100,       32'd7,         32'd2,         33});
    vecs.push_back('{3'b100, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 33});
    vecs.push_back('{3'b110, 32'd20,        32'hFFFF_FFFD, 32'd2,         33});
    vecs.push_back('{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33});
    vecs.push_back('{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'b111, 32'd5,         32'd0,         32'd5,         1});
    vecs.push_back('{3'b100, 32'd7,         32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1});
    vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
    vecs.push_back('{3'b000, 32'd9,         32'd9,         32'd81,        33});

    reset = 1'b1; start_i = 1'b0; funct3_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    #2 reset = 1'b0;
    #1;
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset done", {31'd0, done_o}, 32'd0);
    check("reset result", result_o, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      if (!DIV_EN && v.f3[2]) begin
        v.res = 32'd0;
        v.lat = 1;
      end
      run_op(v.f3, v.a, v.b, lat, res, bf);
      check($sformatf("vec%0d result", i), res, v.res);
      check($sformatf("vec%0d latency", i), lat, v.lat);
      check($sformatf("vec%0d busy", i), {31'd0, bf}, 32'd1);
      @(negedge clk);
      check($sformatf("vec%0d done width", i), {31'd0, done_o}, 32'd0);
      check($sformatf("vec%0d result hold", i), result_o, v.res);
    end

    // Reset in the middle of CALC aborts without a done pulse
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b000; rs1_data_i = 32'd5; rs2_data_i = 32'd6;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort busy", {31'd0, busy_o}, 32'd0);
    check("abort result", result_o, 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done_o) done_cnt++;
    end
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) done_cnt++;
    end
    check("abort no done", done_cnt, 0);
    run_op(3'b011, 32'd3, 32'd4, lat, res, bf);
    check("post-abort mulhu result", res, 32'd0);
    check("post-abort mulhu latency", lat, 33);

    // start_i held high: one done per 34 cycles, mid-op operand changes ignored
    @(negedge clk);
    @(negedge clk);
    done_cnt = 0;
    for (int c = 0; c < 102; c++) begin
      if (c > 0) @(negedge clk);
      if (done_o) begin
        done_cnt++;
        check($sformatf("held done cycle %0d", c), c % 34, 33);
        check($sformatf("held result %0d", c), result_o, 32'd15);
      end
      start_i = 1'b1;
      if (c % 34 == 0) begin
        funct3_i = 3'b000; rs1_data_i = 32'd3; rs2_data_i = 32'd5;
      end else begin
        funct3_i = 3'($urandom_range(0, 7)); rs1_data_i = $urandom; rs2_data_i = $urandom;
      end
    end
    @(negedge clk);
    start_i = 1'b0;
    check("held done count", done_cnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_sequencer.md
MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  request pulse; sampled only in IDLE.
REQ-005 funct3_i  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_data_i  input  32  operand A (multiplicand/dividend).
REQ-007 rs2_data_i  input  32  operand B (multiplier/divisor).
REQ-008 busy_o  output  1  high in CALC and DONE.
REQ-009 done_o  output  1  one-cycle pulse, result valid.
REQ-010 result_o  output  32  result; held stable from DONE until next accepted start.

Function
REQ-011 States SHALL be IDLE, CALC, DONE; encoding is free.
REQ-012 IDLE with start_i=1 SHALL latch funct3_i, rs1_data_i, rs2_data_i, load counter=31 and go to CALC.
REQ-013 start_i SHALL be ignored in CALC and DONE; latched operands SHALL not change while busy.
REQ-014 Signed ops (MULH, MULHSU A only, DIV, REM) SHALL take operand magnitudes on capture and compute unsigned.
REQ-015 MUL family SHALL use radix-2 shift-add over a 64-bit product register, one bit per CALC cycle.
REQ-016 DIV family SHALL use radix-2 restoring division, one quotient bit per CALC cycle.
REQ-017 CALC SHALL last exactly 32 cycles (counter 31 down to 0), then go to DONE.
REQ-018 Entering DONE SHALL apply sign correction: product negated if signs differ (MULHSU: sign of A only); quotient negated if signs differ; remainder takes sign of dividend.
REQ-019 result_o: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
REQ-020 DONE SHALL assert done_o for exactly one cycle and return to IDLE unconditionally.
REQ-021 Normal latency, start accepted to done_o high: 33 cycles.
REQ-022 Divide by zero: IDLE SHALL go directly to DONE; quotient = 32'hFFFF_FFFF, remainder = rs1_data_i; latency 1.
REQ-023 Signed overflow (DIV/REM, A=32'h8000_0000, B=32'hFFFF_FFFF): direct to DONE; quotient = 32'h8000_0000, remainder = 0; latency 1.
REQ-024 Back-to-back: start_i in the cycle after done_o SHALL be accepted; minimum issue interval 34 cycles.

Reset
REQ-025 Reset low SHALL immediately force IDLE, busy_o=0, done_o=0, result_o=0, counter=0, operand/product registers=0.
REQ-026 Reset asserted mid-CALC SHALL abort the operation with no done_o pulse, before or after release.
REQ-027 The first start_i accepted is the one seen on the first rising edge with reset high.

Configuration
REQ-028 Macro MULDIV_DIVIDER_EN SHALL compile the divider datapath in or out.
REQ-029 Defined: all eight funct3 ops SHALL behave as specified above.
REQ-030 Undefined: divider logic absent; funct3_i[2]=1 SHALL go IDLE->DONE with result_o=0, latency 1; MUL ops unchanged.

Verification
REQ-031 MUL 7 x -3 (32'hFFFF_FFFD), start pulse -> done_o 33 cycles later, result_o=32'hFFFF_FFEB.
REQ-032 MULHU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> result_o=32'hFFFF_FFFE; MULH same operands -> 0.
REQ-033 DIV -20/3 -> 32'hFFFF_FFFA; REM -20/3 -> 32'hFFFF_FFFE; DIVU 100/7 -> 14, latency 33.
REQ-034 DIVU 5/0 -> 32'hFFFF_FFFF, REMU 5/0 -> 5, DIV 32'h8000_0000/-1 -> 32'h8000_0000; each done_o after 1 cycle.
REQ-035 Start MUL, assert reset at CALC cycle 10, release, start MULHU 3x4 -> no done_o for the aborted op, new result 0.
REQ-036 start_i held high throughout -> exactly one done_o per 34 cycles, operands changing mid-op have no effect.
